dvsd_mult_arbiter: RTL

Sequencing and arbitration controller for the shared 8x8 gate-level multiplier `dvsd_8216m1`. Two requesters submit operand pairs over valid/ready handshakes. The block grants the multiplier round-robin, drives its bit-level operand inputs from registers, and waits a fixed settle interval for the CMOS-gate datapath to resolve. It then captures the 16-bit product and returns it with the requester ID over a valid/ready response channel.

---
 rtl/dvsd_mult_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dvsd_mult_arbiter.sv
// -----------------------------------------------------------------------------
// dvsd_mult_arbiter
//
// Sequencing and arbitration controller for the shared 8x8 gate-level
// multiplier dvsd_8216m1. Two requesters hand in operand pairs over
// valid/ready. The block grants the multiplier round-robin and drives the
// multiplier's bit-level operand pins from registers. It waits SETTLE_CYCLES
// for the gate datapath to resolve, captures the 16-bit product, and returns
// the product with the owning requester ID over a valid/ready response
// channel.
//
// Parameters
//   SETTLE_CYCLES  cycles the operands are held before the product is
//                  sampled (legal range 1..15)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/ready/a/b       requester 0 handshake and operands
//   req1_valid/ready/a/b       requester 1 handshake and operands
//   mul_a, mul_b               registered operands to the multiplier
//   mul_p                      product from the multiplier
//   rsp_valid/ready            response handshake
//   rsp_p, rsp_id              captured product and owning requester
//   busy                       FSM is not in IDLE
// -----------------------------------------------------------------------------
module dvsd_mult_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic [15:0] mul_p,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_p,
   output logic        rsp_id,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // The counter starts one below the settle length because the cycle in
   // which it reads zero is itself the last settle cycle.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic [7:0]  mul_a_q, mul_a_d;
   logic [7:0]  mul_b_q, mul_b_d;
   logic [15:0] rsp_p_q, rsp_p_d;
   logic        rsp_id_q, rsp_id_d;

   logic        grant_vld;
   logic        grant_id;
   logic        accept;

   // ---------------------------------------------------------------------------
   // Round-robin grant, only offered while IDLE. With both requesters valid,
   // the one that was not granted last wins.
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default at the top,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state_q == ST_IDLE) begin
         case ({req1_valid, req0_valid})
            2'b01: begin
               grant_vld = 1'b1;
               grant_id  = 1'b0;
            end
            2'b10: begin
               grant_vld = 1'b1;
               grant_id  = 1'b1;
            end
            2'b11: begin
               grant_vld = 1'b1;
               grant_id  = ~last_q;
            end
            default: begin
               grant_vld = 1'b0;
               grant_id  = 1'b0;
            end
         endcase
      end
   end

   // NOTE: the readies are masked with rst_n. The FSM already sits in IDLE
   // while reset is held, so without the mask a requester would see ready
   // during reset and believe its request was taken.
   assign req0_ready = rst_n & grant_vld & ~grant_id;
   assign req1_ready = rst_n & grant_vld &  grant_id;

   // A grant is only ever given to a valid requester, so ready alone marks
   // the accept.
   assign accept = req0_ready | req1_ready;

   // ---------------------------------------------------------------------------
   // Next-state and datapath register updates.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      rsp_p_d  = rsp_p_q;
      rsp_id_d = rsp_id_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mul_a_d  = grant_id ? req1_a : req0_a;
               mul_b_d  = grant_id ? req1_b : req0_b;
               rsp_id_d = grant_id;
               last_d   = grant_id;
               cnt_d    = CNT_LOAD;
               state_d  = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == 4'd0) begin
               // Operands have now been stable for SETTLE_CYCLES cycles.
               rsp_p_d = mul_p;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         last_q   <= 1'b1;
         mul_a_q  <= 8'h00;
         mul_b_q  <= 8'h00;
         rsp_p_q  <= 16'h0000;
         rsp_id_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         rsp_p_q  <= rsp_p_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);

endmodule
